// File: rtl/dff_test_pkg.sv
// Shared constants and types for the dff_test register pipeline.
// Holds parameter defaults and legal limits, the edge-monitor counter
// width and the common reset value used by every register stage.
package dff_test_pkg;

   // Parameter defaults: a single-bit, single-stage plain DFF.
   localparam int WIDTH_DEFAULT = 1;
   localparam int DEPTH_DEFAULT = 1;

   // Legal parameter limits, checked at elaboration in the top module.
   localparam int WIDTH_MAX = 64;
   localparam int DEPTH_MAX = 8;

   // Width of the optional rising-edge counter.
   localparam int EDGE_CNT_W = 16;

   // Reset value for every stage; sliced down to the stage width.
   localparam logic [WIDTH_MAX-1:0] RESET_VALUE = '0;

   typedef logic [EDGE_CNT_W-1:0] edge_cnt_t;

endpackage : dff_test_pkg

// File: rtl/dff_test_stage.sv
// One WIDTH-bit rising-edge register with asynchronous active-low clear.
// The top module chains DEPTH of these to form the capture pipeline.
module dff_test_stage
   import dff_test_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d on the rising edge; reset clears immediately without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VALUE[WIDTH-1:0];
      end else begin
         q <= d;
      end
   end

endmodule : dff_test_stage

// File: rtl/dff_test.sv
// dff_test: race-free reference sampling point built from DEPTH cascaded
// rising-edge register stages, WIDTH bits each. d reaches q after DEPTH
// rising edges; there is no combinational path from d to q.
// Optional build macro DFF_TEST_EDGE_MON_EN adds edge_cnt (rising edges
// seen out of reset, wrapping) and q_changed (high for the cycle after an
// edge that changed q).
module dff_test
   import dff_test_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      d,
`ifdef DFF_TEST_EDGE_MON_EN
   output logic [EDGE_CNT_W-1:0] edge_cnt,
   output logic                  q_changed,
`endif
   output logic [WIDTH-1:0]      q
);

   // Elaboration-time guard on the parameter ranges.
   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("dff_test: WIDTH=%0d outside 1..%0d", WIDTH, WIDTH_MAX);
   end
   if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_depth_check
      $error("dff_test: DEPTH=%0d outside 1..%0d", DEPTH, DEPTH_MAX);
   end

   // stage_d[i] is what stage i samples; stage_q[i] is what it holds.
   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [WIDTH-1:0] stage_q [DEPTH];

   // Chain the stages: stage 0 samples d, every later stage its predecessor.
   // Each stage uses non-blocking updates, so the whole chain shifts
   // atomically per edge.
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign stage_d[g] = d;
      end else begin : g_next
         assign stage_d[g] = stage_q[g-1];
      end

      dff_test_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (stage_d[g]),
         .q     (stage_q[g])
      );
   end

   assign q = stage_q[DEPTH-1];

`ifdef DFF_TEST_EDGE_MON_EN
   // Count every rising edge taken out of reset; wraps naturally at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
      end
   end

   // Flag the cycle after an edge whose new q differs from the old q.
   // stage_d[DEPTH-1] is exactly the value the last stage loads this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_changed <= 1'b0;
      end else begin
         q_changed <= (stage_d[DEPTH-1] != stage_q[DEPTH-1]);
      end
   end
`endif

endmodule : dff_test

// File: tb/tb_dff_test.sv
// Self-checking bench for dff_test. Two instances share one clock:
// a default WIDTH=1/DEPTH=1 plain DFF and a WIDTH=8/DEPTH=3 pipeline.
// Clock period is 30: rising edges at 10, 40, 70, ... and falling edges
// at 25, 55, 85, ... The rising edge is applied after a #0, so a d change
// made by the stimulus in the same time step lands before the edge.
module tb_dff_test;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst1_n;
   logic rst3_n;

   initial begin
      clk = 1'b0;
      forever begin
         #10;
         #0 clk = 1'b1;
         #15 clk = 1'b0;
         #5;
      end
   end

   // ---------------- DUTs ----------------
   logic [0:0] d1;
   logic [0:0] q1;
   logic [7:0] d3;
   logic [7:0] q3;
`ifdef DFF_TEST_EDGE_MON_EN
   logic [15:0] edge_cnt1;
   logic        q_changed1;
   logic [15:0] edge_cnt3;
   logic        q_changed3;
`endif

   dff_test #(
      .WIDTH (1),
      .DEPTH (1)
   ) dut1 (
      .clk       (clk),
      .rst_n     (rst1_n),
      .d         (d1),
`ifdef DFF_TEST_EDGE_MON_EN
      .edge_cnt  (edge_cnt1),
      .q_changed (q_changed1),
`endif
      .q         (q1)
   );

   dff_test #(
      .WIDTH (8),
      .DEPTH (3)
   ) dut3 (
      .clk       (clk),
      .rst_n     (rst3_n),
      .d         (d3),
`ifdef DFF_TEST_EDGE_MON_EN
      .edge_cnt  (edge_cnt3),
      .q_changed (q_changed3),
`endif
      .q         (q3)
   );

   // ---------------- scoreboard ----------------
   logic [0:0] exp_q1[$];
   logic [7:0] exp_q3[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic underflow(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=pending_value", tag);
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_until(input time t);
      if ($time < t) #(t - $time);
   endtask

   task automatic drive1(input logic [0:0] v);
      d1 = v;
      exp_q1.push_back(v);
   endtask

   task automatic drive3(input logic [7:0] v);
      d3 = v;
      exp_q3.push_back(v);
   endtask

   task automatic check_q1(input string tag);
      logic [0:0] e;
      if (exp_q1.size() == 0) begin
         underflow(tag);
      end else begin
         e = exp_q1.pop_front();
         check(tag, 64'(q1), 64'(e));
      end
   endtask

   // Stages hold zeros after reset, so the first DEPTH-1 outputs are zero.
   task automatic preload3();
      exp_q3.delete();
      exp_q3.push_back(8'h00);
      exp_q3.push_back(8'h00);
   endtask

   // One DEPTH=3 edge: drive at t_drive, edge at t_drive+10, sample 1 later.
   task automatic step3(input time t_drive, input logic [7:0] v,
                        input string tag, input int edge_no,
                        inout logic [7:0] prev_q);
      logic [7:0] e;
      wait_until(t_drive);
      drive3(v);
      wait_until(t_drive + 11);
      if (exp_q3.size() == 0) begin
         underflow(tag);
      end else begin
         e = exp_q3.pop_front();
         check(tag, 64'(q3), 64'(e));
`ifdef DFF_TEST_EDGE_MON_EN
         check({tag, "_edge_cnt"}, 64'(edge_cnt3), 64'(edge_no));
         check({tag, "_q_changed"}, 64'(q_changed3), 64'(e != prev_q));
`endif
         prev_q = e;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] vals [8];
      logic [7:0] prev_q3;

      rst1_n = 1'b0;
      rst3_n = 1'b0;
      d1     = 1'b0;
      d3     = 8'h00;

      // Reset state, before any clock edge.
      wait_until(5);
      check("reset_q1", 64'(q1), 64'h0);
      check("reset_q3", 64'(q3), 64'h0);
      rst1_n = 1'b1;

      // Normal capture with d set up early.
      drive1(1'b0);
      wait_until(11);
      check_q1("cap_early_0");
      wait_until(30);
      drive1(1'b1);
      wait_until(41);
      check_q1("cap_early_1");

      // d 0->1 in the same time step as the rising edge at 70.
      wait_until(60);
      d1 = 1'b0;
      wait_until(70);
      drive1(1'b1);
      wait_until(71);
      check_q1("simul_0to1");

      // d 1->0 in the same time step as the rising edge at 100.
      wait_until(90);
      d1 = 1'b1;
      wait_until(100);
      drive1(1'b0);
      wait_until(101);
      check_q1("simul_1to0");

      // Hold: d stays 0 across the edge at 130 and the falling edge at 145.
      wait_until(115);
      drive1(1'b0);
      wait_until(131);
      check_q1("hold_0");
      wait_until(146);
      check("fall_hold_0", 64'(q1), 64'h0);

      // Load a 1 and confirm the falling edge at 175 leaves it alone.
      wait_until(150);
      drive1(1'b1);
      wait_until(161);
      check_q1("set_1");
      wait_until(176);
      check("fall_hold_1", 64'(q1), 64'h1);

      // Asynchronous reset between edges clears q at once.
      wait_until(180);
      rst1_n = 1'b0;
      exp_q1.delete();
      wait_until(181);
      check("async_rst_q1", 64'(q1), 64'h0);
      wait_until(185);
      rst1_n = 1'b1;
      drive1(1'b1);
      wait_until(191);
      check_q1("post_rst_1");

      // Reset asserted in the same step as the rising edge at 220: reset wins.
      wait_until(220);
      rst1_n = 1'b0;
      exp_q1.delete();
      wait_until(221);
      check("rst_coincident_q1", 64'(q1), 64'h0);
      wait_until(230);
      rst1_n = 1'b1;

      // DEPTH=3 pipeline: directed values then random traffic.
      vals[0] = 8'hA5;
      vals[1] = 8'h3C;
      vals[2] = 8'hFF;
      for (int i = 3; i < 8; i++) vals[i] = 8'($urandom_range(0, 255));

      wait_until(235);
      rst3_n  = 1'b1;
      preload3();
      prev_q3 = 8'h00;
      for (int k = 0; k < 8; k++) begin
         step3(time'(240 + 30 * k), vals[k], $sformatf("q3_edge%0d", k + 1),
               k + 1, prev_q3);
      end

      // Mid-run reset on the pipeline discards everything in flight.
      wait_until(470);
      rst3_n = 1'b0;
      exp_q3.delete();
      wait_until(471);
      check("async_rst_q3", 64'(q3), 64'h0);
`ifdef DFF_TEST_EDGE_MON_EN
      check("async_rst_edge_cnt", 64'(edge_cnt3), 64'h0);
      check("async_rst_q_changed", 64'(q_changed3), 64'h0);
`endif
      wait_until(475);
      rst3_n  = 1'b1;
      preload3();
      prev_q3 = 8'h00;
      step3(480, 8'h5A, "q3_post_rst_edge1", 1, prev_q3);
      step3(510, 8'hC3, "q3_post_rst_edge2", 2, prev_q3);
      step3(540, 8'h0F, "q3_post_rst_edge3", 3, prev_q3);
      step3(570, 8'h0F, "q3_post_rst_edge4", 4, prev_q3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dff_test
